// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// The PRE state value is always defined here; it is only reachable when
// SERIAL_PATTERN_TX_PREAMBLE_EN is defined in the top module build.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_t;

    localparam int              PRE_W    = 4;
    localparam logic [PRE_W-1:0] PREAMBLE = 4'b1010;

endpackage

// File: rtl/serial_pattern_tx_piso.sv
// Parallel-in serial-out shift register: load has priority over shift,
// shifts left filling zeros, MSB is the serial output. Because it fills
// with zeros, it is empty once a whole frame has been shifted out, which
// is what keeps the serial line low between frames.
module piso_shift_reg #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_shift,
    output logic         o_msb
);

    logic [W-1:0] r_sr;

    // load a new frame or shift one bit toward the MSB
    always_ff @(posedge clk) begin
        if (rst)          r_sr <= '0;
        else if (i_load)  r_sr <= i_load_val;
        else if (i_shift) r_sr <= {r_sr[W-2:0], 1'b0};
    end

    assign o_msb = r_sr[W-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: sends a W-bit pattern MSB-first, repeated
// max(repeats,1) times with GAP idle cycles between frames.
// Optional macro SERIAL_PATTERN_TX_PREAMBLE_EN: prefix every frame with the
// 4-bit preamble 1010 (state PRE). The preamble is simply prepended to the
// shift register contents, so PRE and SEND share one bit counter.
module serial_pattern_tx
    import serial_tx_pkg::*;
#(
    parameter int W     = 6,
    parameter int CNT_W = 4,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     pattern,
    input  logic [CNT_W-1:0] repeats,
    output logic             a,
    output logic             a_valid,
    output logic             busy,
    output logic             done
);

`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
    localparam int        FL       = W + PRE_W;
    localparam tx_state_t FIRST_ST = ST_PRE;
`else
    localparam int        FL       = W;
    localparam tx_state_t FIRST_ST = ST_SEND;
`endif
    localparam int BIT_CW = $clog2(FL);
    localparam int GAP_CW = (GAP > 1) ? $clog2(GAP) : 1;

    tx_state_t         r_state, w_state_nxt;
    logic [W-1:0]      r_shadow;
    logic [CNT_W-1:0]  r_frames;
    logic [BIT_CW-1:0] r_bit;
    logic [GAP_CW-1:0] r_gap;
    logic              r_a_valid, r_busy, r_done;
    logic              w_valid_nxt, w_busy_nxt, w_done_nxt;

    logic              w_accept, w_frame_end, w_last_frame, w_gap_end;
    logic              w_load, w_shift, w_msb;
    logic [W-1:0]      w_pat_src;
    logic [FL-1:0]     w_load_val;

    assign w_accept     = start && !r_busy && (r_state == ST_IDLE);
    assign w_frame_end  = (r_state == ST_SEND) && (r_bit == BIT_CW'(FL - 1));
    assign w_last_frame = (r_frames <= CNT_W'(1));
    assign w_gap_end    = (r_state == ST_GAP) && (r_gap == GAP_CW'(GAP - 1));
    assign w_shift      = (r_state == ST_PRE) || (r_state == ST_SEND);
    // reload on accept, after a gap, or straight away for back-to-back frames
    assign w_load       = w_accept || w_gap_end ||
                          (w_frame_end && !w_last_frame && (GAP == 0));
    assign w_pat_src    = w_accept ? pattern : r_shadow;
`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
    assign w_load_val   = {PREAMBLE, w_pat_src};
`else
    assign w_load_val   = w_pat_src;
`endif

    piso_shift_reg #(.W(FL)) u_piso (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_shift    (w_shift),
        .o_msb      (w_msb)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = FIRST_ST;
`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
            ST_PRE:  if (r_bit == BIT_CW'(PRE_W - 1)) w_state_nxt = ST_SEND;
`endif
            ST_SEND: if (w_frame_end) begin
                if (w_last_frame)  w_state_nxt = ST_IDLE;
                else if (GAP == 0) w_state_nxt = FIRST_ST;
                else               w_state_nxt = ST_GAP;
            end
            ST_GAP:  if (w_gap_end) w_state_nxt = FIRST_ST;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // next values of the registered outputs
    always_comb begin
        w_valid_nxt = (w_state_nxt == ST_PRE) || (w_state_nxt == ST_SEND);
        w_busy_nxt  = (w_state_nxt != ST_IDLE);
        w_done_nxt  = w_frame_end && w_last_frame;
    end

    // output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_a_valid <= w_valid_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // shadow pattern, frame, bit and gap counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= '0;
            r_frames <= '0;
            r_bit    <= '0;
            r_gap    <= '0;
        end else begin
            if (w_accept) begin
                r_shadow <= pattern;
                r_frames <= (repeats == '0) ? CNT_W'(1) : repeats;
            end else if (w_frame_end && r_frames != '0) begin
                r_frames <= r_frames - CNT_W'(1);
            end

            if (w_load || w_frame_end) r_bit <= '0;
            else if (w_shift)          r_bit <= r_bit + BIT_CW'(1);

            if (r_state == ST_GAP) r_gap <= r_gap + GAP_CW'(1);
            else                   r_gap <= '0;
        end
    end

    // the shift register is empty outside frames, so its MSB is 0 then
    assign a       = w_msb;
    assign a_valid = r_a_valid;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed self-checking bench for serial_pattern_tx (W=6, CNT_W=4, GAP=2).
// Expectations follow SERIAL_PATTERN_TX_PREAMBLE_EN when it is defined.
module tb_serial_pattern_tx;

    localparam int W = 6;
    localparam int CNT_W = 4;
    localparam int GAP = 2;
`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
    localparam int FL = W + 4;
`else
    localparam int FL = W;
`endif

    logic             clk = 1'b0;
    logic             rst, start;
    logic [W-1:0]     pattern;
    logic [CNT_W-1:0] repeats;
    logic             a, a_valid, busy, done;

    int n_tot = 0;
    int n_bad = 0;
    int busy_cnt, done_cnt;

    serial_pattern_tx #(.W(W), .CNT_W(CNT_W), .GAP(GAP)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pattern (pattern),
        .repeats (repeats),
        .a       (a),
        .a_valid (a_valid),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one edge and sample 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
        if (busy) busy_cnt++;
        if (done) done_cnt++;
    endtask

    function automatic logic [FL-1:0] frame_of(input logic [W-1:0] p);
`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
        return {4'b1010, p};
`else
        return p;
`endif
    endfunction

    // check FL frame cycles starting at the current cycle
    task automatic check_frame(input string tag, input logic [W-1:0] p);
        logic [FL-1:0] fr;
        fr = frame_of(p);
        for (int i = 0; i < FL; i++) begin
            chk({tag, "_a"}, a, fr[FL-1-i]);
            chk({tag, "_vld"}, a_valid, 1'b1);
            chk({tag, "_busy"}, busy, 1'b1);
            chk({tag, "_done"}, done, 1'b0);
            tick();
        end
    endtask

    task automatic check_idle_done(input string tag);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_vld"}, a_valid, 1'b0);
        chk({tag, "_a"}, a, 1'b0);
    endtask

    task automatic go(input logic [W-1:0] p, input logic [CNT_W-1:0] r);
        pattern = p;
        repeats = r;
        start = 1'b1;
        busy_cnt = 0;
        done_cnt = 0;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pattern = '0; repeats = '0;
        busy_cnt = 0; done_cnt = 0;

        // reset held two cycles
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_a", a, 1'b0);
            chk("rst_vld", a_valid, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_done", done, 1'b0);
        end
        rst = 1'b0;
        tick();

        // single frame 110011
        go(6'b110011, 4'd1);
        check_frame("single", 6'b110011);
        check_idle_done("single_end");
        tick();
        chk("single_done_once", done, 1'b0);
        chk("single_busy_cnt", busy_cnt, FL);

        // three frames with 2-cycle gaps
        go(6'b101010, 4'd3);
        for (int f = 0; f < 3; f++) begin
            check_frame("rep", 6'b101010);
            if (f < 2) begin
                for (int g = 0; g < GAP; g++) begin
                    chk("gap_a", a, 1'b0);
                    chk("gap_vld", a_valid, 1'b0);
                    chk("gap_busy", busy, 1'b1);
                    tick();
                end
            end
        end
        check_idle_done("rep_end");
        tick(); tick();
`ifdef SERIAL_PATTERN_TX_PREAMBLE_EN
        chk("rep_busy_cnt", busy_cnt, 34);
`else
        chk("rep_busy_cnt", busy_cnt, 22);
`endif
        chk("rep_done_cnt", done_cnt, 1);

        // start and pattern activity while busy are ignored
        begin
            logic [FL-1:0] fr;
            fr = frame_of(6'b110011);
            go(6'b110011, 4'd1);
            for (int i = 0; i < FL; i++) begin
                chk("ign_a", a, fr[FL-1-i]);
                chk("ign_vld", a_valid, 1'b1);
                start = (i == FL - W + 2);
                pattern = (i == FL - W + 2) ? 6'b000111 : ~pattern;
                repeats = 4'd2;
                tick();
            end
            start = 1'b0;
            check_idle_done("ign_end");
            tick(); tick(); tick();
            chk("ign_done_cnt", done_cnt, 1);
            chk("ign_idle", busy, 1'b0);
        end

        // reset during bit 3
        go(6'b110011, 4'd2);
        for (int i = 0; i < FL - W + 3; i++) tick();
        chk("mid_pre_vld", a_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_a", a, 1'b0);
        chk("mid_vld", a_valid, 1'b0);
        chk("mid_busy", busy, 1'b0);
        chk("mid_done", done, 1'b0);
        tick(); tick(); tick();
        chk("mid_no_done", done_cnt, 0);
        go(6'b110011, 4'd1);
        check_frame("post_rst", 6'b110011);
        check_idle_done("post_rst_end");
        tick();

        // repeats=0 sends one frame
        go(6'b100101, 4'd0);
        check_frame("rep0", 6'b100101);
        check_idle_done("rep0_end");
        tick(); tick(); tick();
        chk("rep0_busy_cnt", busy_cnt, FL);
        chk("rep0_done_cnt", done_cnt, 1);

        // start held through the done cycle: restart after one idle cycle
        pattern = 6'b110011; repeats = 4'd1; start = 1'b1;
        tick();
        check_frame("hold1", 6'b110011);
        check_idle_done("hold_done");
        tick();
        start = 1'b0;
        pattern = 6'b011110;
        check_frame("hold2", 6'b110011);
        check_idle_done("hold2_end");
        tick();
        chk("hold_idle", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

    // global timeout guard
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
